// File: rtl/mul8_dot_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul8_dot_acc                                                 |
// | Description : Sums runs of LEN 16-bit products into a dot-product result   |
// |               returned over valid/ready. Optional saturation: define       |
// |               MUL8_DOT_ACC_SAT_EN.                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mul8_dot_acc #(
    parameter int LEN   = 16,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);
    localparam int                 c_cnt_w    = $clog2(LEN + 1);
    localparam logic [1:0]         c_st_idle  = 2'd0;
    localparam logic [1:0]         c_st_acc   = 2'd1;
    localparam logic [1:0]         c_st_done  = 2'd2;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(LEN - 1);
    localparam logic               c_single   = (LEN == 1);

    if (LEN < 1 || LEN > 1024) begin : g_len_bad
        $error("mul8_dot_acc: LEN must be in 1..1024");
    end
    if (ACC_W < 16 || ACC_W > 32) begin : g_acc_w_bad
        $error("mul8_dot_acc: ACC_W must be in 16..32");
    end

    logic [1:0]         state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   add_val;
    logic               accept, first, add, finish, handoff;

    assign prod_ext = ACC_W'(in_prod);
    assign accept   = in_valid & in_ready_q & ~clr;
    assign first    = accept & (state_q == c_st_idle);
    assign add      = accept & (state_q == c_st_acc);
    assign finish   = (first & c_single) | (add & (cnt_q == c_cnt_last));
    assign handoff  = out_valid_q & out_ready & (state_q == c_st_done);

`ifdef MUL8_DOT_ACC_SAT_EN
    logic             ovf_q, ovf_d;
    logic             out_ovf_q, out_ovf_d;
    logic             add_ovf;
    logic [ACC_W:0]   sum_ext;

    // Once clamped, the run stays clamped even if later products are zero.
    always_comb begin
        sum_ext = {1'b0, acc_q} + {1'b0, prod_ext};
        add_ovf = ovf_q | sum_ext[ACC_W];
        add_val = add_ovf ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
    end

    always_comb begin
        ovf_d     = ovf_q;
        out_ovf_d = out_ovf_q;
        if (clr) begin
            ovf_d     = 1'b0;
            out_ovf_d = 1'b0;
        end else begin
            if (first) begin
                ovf_d = 1'b0;
            end else if (add) begin
                ovf_d = add_ovf;
            end
            if (finish) begin
                out_ovf_d = first ? 1'b0 : add_ovf;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q     <= 1'b0;
            out_ovf_q <= 1'b0;
        end else begin
            ovf_q     <= ovf_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign out_ovf = out_ovf_q;
`else
    assign add_val = acc_q + prod_ext;
    assign out_ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= c_st_idle;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = c_st_idle;
        end else begin
            case (state_q)
                c_st_idle: if (first)   state_d = c_single ? c_st_done : c_st_acc;
                c_st_acc:  if (finish)  state_d = c_st_done;
                c_st_done: if (handoff) state_d = c_st_idle;
                default:                state_d = c_st_idle;
            endcase
        end
    end

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_sum_d = out_sum_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else begin
            if (first) begin
                acc_d = prod_ext;
                cnt_d = c_cnt_w'(1);
            end else if (add) begin
                acc_d = add_val;
                cnt_d = cnt_q + c_cnt_w'(1);
            end else if (handoff) begin
                cnt_d = '0;
            end
            if (finish) begin
                out_sum_d = first ? prod_ext : add_val;
            end
        end
        // Registered from next state so in_ready never sees in_valid combinationally.
        out_valid_d = (state_d == c_st_done);
        in_ready_d  = (state_d != c_st_done);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign busy      = (state_q == c_st_acc);

endmodule
`default_nettype wire

// File: doc/mul8_dot_acc.md
Name: mul8_dot_acc

Overview:
- Sequential accumulator placed directly downstream of the 8x8 approximate multipliers.
- Consumes the 16-bit product bus O of one multiplier instance.
- Sums a fixed-length run of LEN products into a dot-product result.
- Presents the result over a valid/ready handshake, so approximate multipliers can be characterised and used in MAC/filter datapaths.

Parameters:
- LEN, 16: number of products per dot-product run; legal range 1..1024.
- ACC_W, 20: accumulator and result width in bits; legal range 16..32. Full precision requires ACC_W >= 16+ceil(log2(LEN)).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous abort; discards any partial run.
- in_valid  in  1  in_prod holds a valid product.
- in_ready  out  1  block can accept a product this cycle.
- in_prod  in  16  unsigned product, connected to multiplier output O.
- out_valid  out  1  out_sum holds a completed run.
- out_ready  in  1  downstream accepts out_sum.
- out_sum  out  ACC_W  unsigned dot-product result.
- out_ovf  out  1  overflow flag for the current result.
- busy  out  1  a run is in progress (state ACC).

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst=1: state=IDLE, acc=0, cnt=0, out_sum=0, out_valid=0, out_ovf=0, busy=0, in_ready=0. in_ready rises on the first clk edge after rst is released.
- Accept rule: a product is accepted on a clk edge where in_valid=1, in_ready=1 and clr=0.
- in_ready = 1 in IDLE and ACC, 0 in DONE. It is a registered function of state only and never depends combinationally on in_valid.
- IDLE:
  - On accept: acc <= in_prod (load, not add), cnt <= 1, ovf <= 0.
  - If LEN=1, go to DONE; otherwise go to ACC.
- ACC:
  - On accept: acc <= acc + in_prod, cnt <= cnt+1.
  - When the accepted product is the LEN-th, transfer the sum to out_sum and go to DONE.
  - Idle cycles with in_valid=0 are allowed and hold all state.
- DONE:
  - out_valid=1; out_sum and out_ovf are held stable.
  - On out_valid & out_ready: out_valid <= 0, cnt <= 0, go to IDLE.
  - A new product cannot be accepted in the same cycle as the handoff.
- Latency: out_valid rises exactly one clk after the edge that accepts the LEN-th product. Maximum throughput is one run per LEN+1 cycles when out_ready is held at 1.
- clr: takes priority over accept in every state. Next state is IDLE, with acc, cnt, out_valid and out_ovf cleared; in_prod that cycle is dropped. clr in DONE discards an unconsumed result.
- Arithmetic:
  - in_prod is zero-extended to ACC_W.
  - Overflow means the sum exceeds 2^ACC_W-1.
  - Without the optional feature, sums wrap modulo 2^ACC_W and out_ovf is tied 0.
- busy = (state==ACC).
- cnt width is ceil(log2(LEN+1)).
- Elaboration error if LEN or ACC_W is outside its legal range.

Optional Feature:
- Macro: MUL8_DOT_ACC_SAT_EN.
- Defined:
  - Each add is checked for carry out of ACC_W bits.
  - On overflow, acc clamps to 2^ACC_W-1 and stays clamped for the rest of the run.
  - A sticky ovf bit is set and copied to out_ovf together with out_sum.
- Undefined: wrap-around arithmetic, out_ovf constant 0, no saturation logic synthesised.

Test Plan:
- LEN=4, ACC_W=20, out_ready=1: products 100, 200, 300, 400 on consecutive cycles -> out_valid=1 one cycle after the 4th accept, out_sum=1000, out_ovf=0. Next run's in_ready=1 the cycle after handoff.
- LEN=4, ACC_W=20: four products of 65025 (255*255) with in_valid gaps of 0, 2 and 5 cycles -> out_sum=260100. busy=1 throughout the gaps.
- LEN=4: out_ready=0 for 6 cycles after completion -> out_valid, out_sum and out_ovf stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> a single handoff.
- LEN=4, ACC_W=17: four products of 65025:
  - With MUL8_DOT_ACC_SAT_EN -> out_sum=131071, out_ovf=1.
  - Without it -> out_sum=129028, out_ovf=0.
- LEN=4: clr after 2 accepted products, then 10, 20, 30, 40 -> out_sum=100. Also assert clr while in DONE -> out_valid drops next cycle and the result is lost.
- LEN=1: sequence 7, 9 with out_ready=1 -> two results, 7 then 9, each one cycle after its accept. Assert rst asynchronously mid-run (between clk edges) -> outputs zero immediately, and the following run sums from 0.
